// File: rtl/prog_loader.sv
// Byte-stream program loader for processor Z's instruction RAM.
// Accepts a 16-bit big-endian word count followed by that many 32-bit
// words (MSB first), writes each word through the addr/wEn/wDat port,
// then raises working so the processor can begin fetching.
module prog_loader #(
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 512,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wEn,
    output logic [31:0]       wDat,
    output logic              working,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] BYTES  = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] RUN    = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       DEPTH_LEN = 17'(DEPTH);

    logic [2:0]  state;
    logic [15:0] wordLen;
    logic [1:0]  byteIdx;
    logic        xfer;
    logic [16:0] lenFull;
    logic        lastWord;

    // A byte moves only when the stream offers it and the loader is gathering.
    assign xfer = byte_valid & byte_ready;

    // Full header value as it will be once the low byte lands in LEN_LO.
    assign lenFull = {1'b0, wordLen[15:8], byte_data};

    // The word being written in WRITE is the last one of the program.
    assign lastWord = (32'(word_cnt) + 32'd1) == 32'(wordLen);

    // Output decode from the registered state only; byte_ready never looks at byte_valid.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave one unassigned and infer a latch.
        byte_ready = 1'b0;
        wEn        = 1'b0;
        working    = 1'b0;
        error      = 1'b0;
        case (state)
            LEN_HI, LEN_LO, BYTES: byte_ready = 1'b1;
            WRITE:                 wEn        = 1'b1;
            RUN:                   working    = 1'b1;
            ERR:                   error      = 1'b1;
            default:               ;
        endcase
    end

    // Load sequencer: header capture, word assembly, RAM write and address/count advance.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, matching the hardware.
        if (reset) begin
            state    <= IDLE;
            addr     <= BASE;
            wDat     <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
            wordLen  <= '0;
            byteIdx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // Only a start leaves the parked states; a reload always restarts at BASE.
                IDLE, RUN, ERR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        addr     <= BASE;
                        word_cnt <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        wordLen[15:8] <= byte_data;
                        state         <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        wordLen[7:0] <= byte_data;
                        byteIdx      <= '0;
                        if (lenFull == 17'd0 || lenFull > DEPTH_LEN) begin
                            state <= ERR;
                        end else begin
                            state <= BYTES;
                        end
                    end
                end
                BYTES: begin
                    if (xfer) begin
                        wDat    <= {wDat[23:0], byte_data};
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                // wEn is high for this one cycle; advance only after the RAM has captured the word.
                WRITE: begin
                    addr     <= addr + ADDR_W'(1);
                    word_cnt <= word_cnt + (ADDR_W + 1)'(1);
                    byteIdx  <= '0;
                    if (lastWord) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end else begin
                        state <= BYTES;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a table of per-cycle vectors for the
// single-word load and bad-length headers, then hand-written sequences for
// multi-word loads, a stalled stream, reload from RUN and reset mid-load.
module tb_prog_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [8:0]  addr;
    logic        wEn;
    logic [31:0] wDat;
    logic        working;
    logic        done;
    logic        error;
    logic [9:0]  word_cnt;

    int nVec = 0;
    int nErr = 0;

    prog_loader #(.ADDR_W(9), .DEPTH(512), .BASE_ADDR(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .addr       (addr),
        .wEn        (wEn),
        .wDat       (wDat),
        .working    (working),
        .done       (done),
        .error      (error),
        .word_cnt   (word_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle: inputs for this cycle, outputs expected during it.
    typedef struct {
        logic        s;
        logic        bv;
        logic [7:0]  bd;
        logic        rdy;
        logic        we;
        logic [8:0]  ad;
        logic [31:0] dat;
        logic        chkD;
        logic        work;
        logic        dn;
        logic        err;
        logic [9:0]  cnt;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic s, input logic bv, input logic [7:0] bd,
                                input logic rdy, input logic we, input logic [8:0] ad,
                                input logic [31:0] dat, input logic chkD, input logic work,
                                input logic dn, input logic err, input logic [9:0] cnt);
        vec_t v;
        v.s = s; v.bv = bv; v.bd = bd; v.rdy = rdy; v.we = we; v.ad = ad;
        v.dat = dat; v.chkD = chkD; v.work = work; v.dn = dn; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Apply inputs at a falling edge and move to the next falling edge.
    task automatic drive(input logic s, input logic bv, input logic [7:0] bd);
        start      = s;
        byte_valid = bv;
        byte_data  = bd;
        @(negedge clock);
    endtask

    task automatic chkVec(input int i, input vec_t v);
        check($sformatf("v%0d byte_ready", i), 32'(byte_ready), 32'(v.rdy));
        check($sformatf("v%0d wEn", i),        32'(wEn),        32'(v.we));
        check($sformatf("v%0d addr", i),       32'(addr),       32'(v.ad));
        if (v.chkD) check($sformatf("v%0d wDat", i), wDat, v.dat);
        check($sformatf("v%0d working", i),    32'(working),    32'(v.work));
        check($sformatf("v%0d done", i),       32'(done),       32'(v.dn));
        check($sformatf("v%0d error", i),      32'(error),      32'(v.err));
        check($sformatf("v%0d word_cnt", i),   32'(word_cnt),   32'(v.cnt));
    endtask

    // Stream one word (optional stall after byte 2) and check its WRITE cycle.
    task automatic writeWord(input logic [31:0] word, input int idx, input int gap, input bit last);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("w%0d b%0d byte_ready", idx, b), 32'(byte_ready), 32'd1);
            check($sformatf("w%0d b%0d wEn", idx, b),        32'(wEn),        32'd0);
            check($sformatf("w%0d b%0d working", idx, b),    32'(working),    32'd0);
            if (b == 0) begin
                check($sformatf("w%0d addr", idx),     32'(addr),     32'(idx));
                check($sformatf("w%0d word_cnt", idx), 32'(word_cnt), 32'(idx));
            end
            drive(1'b0, 1'b1, word[31-8*b -: 8]);
            if (b == 1) begin
                for (int g = 0; g < gap; g++) begin
                    check($sformatf("w%0d gap%0d wEn", idx, g),        32'(wEn),        32'd0);
                    check($sformatf("w%0d gap%0d byte_ready", idx, g), 32'(byte_ready), 32'd1);
                    drive(1'b0, 1'b0, 8'hA5);
                end
            end
        end
        check($sformatf("w%0d write wEn", idx),        32'(wEn),        32'd1);
        check($sformatf("w%0d write byte_ready", idx), 32'(byte_ready), 32'd0);
        check($sformatf("w%0d write working", idx),    32'(working),    32'd0);
        check($sformatf("w%0d write addr", idx),       32'(addr),       32'(idx));
        check($sformatf("w%0d write wDat", idx),       wDat,            word);
        // byte_valid high during WRITE must not be consumed.
        drive(1'b0, 1'b1, 8'hCC);
        if (last) begin
            check($sformatf("w%0d done", idx),     32'(done),     32'd1);
            check($sformatf("w%0d working", idx),  32'(working),  32'd1);
            check($sformatf("w%0d wEn off", idx),  32'(wEn),      32'd0);
            check($sformatf("w%0d final cnt", idx),  32'(word_cnt), 32'(idx + 1));
            check($sformatf("w%0d final addr", idx), 32'(addr),     32'(idx + 1));
        end
    endtask

    logic [31:0] prog3[3];

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        prog3[0]   = 32'h1003002A;
        prog3[1]   = 32'h10040005;
        prog3[2]   = 32'h20340000;

        //            s  bv  bd     rdy we ad    dat            chkD wrk dn err cnt
        tbl[0]  = mk(1, 1, 8'hFF, 0, 0, 9'd0, 32'h00000000, 1,  0,  0, 0, 10'd0);
        tbl[1]  = mk(0, 1, 8'h00, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);
        tbl[2]  = mk(0, 1, 8'h01, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);
        tbl[3]  = mk(0, 1, 8'h10, 1, 0, 9'd0, 32'h00000000, 1,  0,  0, 0, 10'd0);
        tbl[4]  = mk(1, 1, 8'h03, 1, 0, 9'd0, 32'h00000010, 1,  0,  0, 0, 10'd0);
        tbl[5]  = mk(0, 1, 8'h00, 1, 0, 9'd0, 32'h00001003, 1,  0,  0, 0, 10'd0);
        tbl[6]  = mk(0, 1, 8'h2A, 1, 0, 9'd0, 32'h00100300, 1,  0,  0, 0, 10'd0);
        tbl[7]  = mk(0, 0, 8'h00, 0, 1, 9'd0, 32'h1003002A, 1,  0,  0, 0, 10'd0);
        tbl[8]  = mk(0, 1, 8'h55, 0, 0, 9'd1, 32'h1003002A, 1,  1,  1, 0, 10'd1);
        tbl[9]  = mk(0, 0, 8'h00, 0, 0, 9'd1, 32'h1003002A, 1,  1,  0, 0, 10'd1);
        tbl[10] = mk(1, 0, 8'h00, 0, 0, 9'd1, 32'h0,        0,  1,  0, 0, 10'd1);
        tbl[11] = mk(0, 1, 8'h00, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);
        tbl[12] = mk(0, 1, 8'h00, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);
        tbl[13] = mk(0, 1, 8'h12, 0, 0, 9'd0, 32'h0,        0,  0,  0, 1, 10'd0);
        tbl[14] = mk(1, 0, 8'h00, 0, 0, 9'd0, 32'h0,        0,  0,  0, 1, 10'd0);
        tbl[15] = mk(0, 1, 8'h02, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);
        tbl[16] = mk(0, 1, 8'h01, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);
        tbl[17] = mk(0, 0, 8'h00, 0, 0, 9'd0, 32'h0,        0,  0,  0, 1, 10'd0);
        tbl[18] = mk(1, 1, 8'h00, 0, 0, 9'd0, 32'h0,        0,  0,  0, 1, 10'd0);
        tbl[19] = mk(0, 0, 8'h00, 1, 0, 9'd0, 32'h0,        0,  0,  0, 0, 10'd0);

        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Single-word load, ignored start/bytes, zero and 513 length headers.
        for (int i = 0; i < 20; i++) begin
            chkVec(i, tbl[i]);
            drive(tbl[i].s, tbl[i].bv, tbl[i].bd);
        end

        // Three-word load from LEN_HI, with a 5-cycle stall inside the second word.
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h03);
        writeWord(prog3[0], 0, 0, 1'b0);
        writeWord(prog3[1], 1, 5, 1'b0);
        writeWord(prog3[2], 2, 0, 1'b1);
        drive(1'b0, 1'b0, 8'h00);
        check("n3 done cleared", 32'(done),    32'd0);
        check("n3 still working", 32'(working), 32'd1);

        // Reload from RUN with a single DEADBEEF word.
        drive(1'b1, 1'b0, 8'h00);
        check("reload working low", 32'(working),    32'd0);
        check("reload byte_ready",  32'(byte_ready), 32'd1);
        check("reload addr",        32'(addr),       32'd0);
        check("reload word_cnt",    32'(word_cnt),   32'd0);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h01);
        writeWord(32'hDEADBEEF, 0, 0, 1'b1);
        drive(1'b0, 1'b0, 8'h00);

        // N=2 load, reset after six data bytes.
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h02);
        writeWord(32'h11223344, 0, 0, 1'b0);
        drive(1'b0, 1'b1, 8'h55);
        drive(1'b0, 1'b1, 8'h66);
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        reset      = 1'b1;
        #1;
        check("rst byte_ready", 32'(byte_ready), 32'd0);
        check("rst wEn",        32'(wEn),        32'd0);
        check("rst addr",       32'(addr),       32'd0);
        check("rst wDat",       wDat,            32'd0);
        check("rst working",    32'(working),    32'd0);
        check("rst done",       32'(done),       32'd0);
        check("rst error",      32'(error),      32'd0);
        check("rst word_cnt",   32'(word_cnt),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("post-rst%0d byte_ready", c), 32'(byte_ready), 32'd0);
            check($sformatf("post-rst%0d wEn", c),        32'(wEn),        32'd0);
            check($sformatf("post-rst%0d wDat", c),       wDat,            32'd0);
            check($sformatf("post-rst%0d working", c),    32'(working),    32'd0);
            check($sformatf("post-rst%0d word_cnt", c),   32'(word_cnt),   32'd0);
            drive(1'b0, 1'b1, 8'h88);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
